prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 110 +++++++++++
 tb/tb_prog_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: assembles 6-bit half-words (low half first) into 12-bit
// instructions, writes them to the 8-entry instruction memory, then checks a
// trailing XOR checksum and raises done (CPU enable) or err.
//
// state | meaning
// ------+-------------------------------------------------------------
// LO    | waiting for the low half of instruction addr
// HI    | low half held in lo_q, waiting for the high half; issues the write
// CHK   | all instructions written, waiting for the checksum half
// DONE  | checksum matched; done held until reset
// ERR   | checksum mismatched; err held until reset
module prog_loader #(
  parameter int HALF_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_WORDS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [HALF_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [2*HALF_WIDTH-1:0] wr_data,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_LO   = 3'd0,
    S_HI   = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_t                  state;
  logic [HALF_WIDTH-1:0]   lo_q;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [HALF_WIDTH-1:0]   chk;
  logic                    xfer;

  assign xfer = in_valid && in_ready;

  // Load sequencer: handshake, word assembly, memory write strobe and checksum verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_LO;
      lo_q     <= '0;
      addr     <= '0;
      chk      <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_LO: begin
          in_ready <= 1'b1;
          if (xfer) begin
            lo_q  <= in_data;
            chk   <= chk ^ in_data;
            state <= S_HI;
          end
        end
        S_HI: begin
          in_ready <= 1'b1;
          if (xfer) begin
            chk     <= chk ^ in_data;
            wr_data <= {in_data, lo_q};
            wr_addr <= addr;
            wr_en   <= 1'b1;
            if (addr == LAST_ADDR) begin
              state <= S_CHK;
            end else begin
              addr  <= addr + ADDR_WIDTH'(1);
              state <= S_LO;
            end
          end
        end
        S_CHK: begin
          in_ready <= 1'b1;
          if (xfer) begin
            // The checksum half itself is compared, never folded into chk.
            in_ready <= 1'b0;
            if (in_data == chk) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_DONE: in_ready <= 1'b0;
        S_ERR:  in_ready <= 1'b0;
        default: begin
          in_ready <= 1'b0;
          state    <= S_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  in_data = '0;
  logic        in_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [5:0] halves [17];

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_stream(input logic [5:0] cks);
    for (int i = 0; i < 17; i++) halves[i] = 6'h00;
    halves[0]  = 6'h01;
    halves[1]  = 6'h20;
    halves[16] = cks;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rdy"},  in_ready, 0);
    check_eq({tag, "_wren"}, wr_en,    0);
    check_eq({tag, "_addr"}, wr_addr,  0);
    check_eq({tag, "_data"}, wr_data,  0);
    check_eq({tag, "_done"}, done,     0);
    check_eq({tag, "_err"},  err,      0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rdy_after_rst", in_ready, 1);
  endtask

  // Offer half i for one accepting edge (optionally preceded by an idle cycle).
  task automatic send_half(input int i, input bit gapped);
    if (gapped) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 6'h3f;
      @(posedge clk);
      #1;
      check_eq("gap_wren", wr_en, 0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = halves[i];
    check_eq("rdy_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    if (i < 16 && (i % 2) == 1) begin
      check_eq("wren_hi", wr_en, 1);
      check_eq("wr_addr", wr_addr, i / 2);
      check_eq("wr_data", wr_data, {halves[i], halves[i-1]});
    end else begin
      check_eq("wren_lo", wr_en, 0);
    end
  endtask

  task automatic run_load(input bit gapped, input bit good);
    for (int i = 0; i < 17; i++) send_half(i, gapped);
    check_eq("end_done", done, good ? 1 : 0);
    check_eq("end_err",  err,  good ? 0 : 1);
    check_eq("end_rdy",  in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic post_traffic(input bit good);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 6'($urandom_range(0, 63));
      @(posedge clk);
      #1;
      check_eq("post_wren", wr_en, 0);
      check_eq("post_done", done, good ? 1 : 0);
      check_eq("post_err",  err,  good ? 0 : 1);
      check_eq("post_rdy",  in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    // Continuous load with correct checksum (0x01 ^ 0x20 = 0x21).
    set_stream(6'h21);
    apply_reset();
    run_load(1'b0, 1'b1);
    post_traffic(1'b1);

    // Bad checksum.
    set_stream(6'h20);
    apply_reset();
    run_load(1'b0, 1'b0);
    post_traffic(1'b0);

    // Gapped valid.
    set_stream(6'h21);
    apply_reset();
    run_load(1'b1, 1'b1);

    // Reset asserted while the high half of word 4 is being offered.
    apply_reset();
    for (int i = 0; i < 9; i++) send_half(i, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = halves[9];
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_rdy", in_ready, 1);
    run_load(1'b0, 1'b1);

    // Valid held high through reset release: first accept must follow in_ready.
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = halves[0];
    @(posedge clk);
    #1;
    check_eq("relrst_rdy_held", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("relrst_rdy", in_ready, 1);
    check_eq("relrst_wren", wr_en, 0);
    run_load(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
